axis_slave_rx: RTL and testbench
================================

# axis_slave_rx

Receiving end of the team's 32-bit valid/ready streaming handshake. It accepts words from a streaming master into a small FIFO and drains the FIFO at a fixed, programmable rate, which exercises master backpressure. Each drained word is checked against an incrementing-sequence expectation. It is the counterpart to the incrementing-counter stream masters and is the standard sink in handshake testbenches and loopback builds.

## Interface
- DATA_W, 32, data word width
- DEPTH, 4, FIFO depth in words; power of two, ≥2
- DRAIN_PERIOD, 3, one pop attempt every DRAIN_PERIOD cycles; ≥1 (1 = every cycle)
- ERR_W, 16, width of error counter

- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- data  in  DATA_W  word from master
- valid  in  1  master word valid
- ready  out  1  slave can accept this cycle
- level  out  $clog2(DEPTH)+1  current FIFO occupancy
- beat_cnt  out  32  accepted handshakes since reset
- last_data  out  DATA_W  most recently drained word
- err_cnt  out  ERR_W  sequence mismatches since reset
- seq_err  out  1  one-cycle pulse per mismatch

## Operation
- Reset (rst_n==0 at a clk edge) sets the following: level=0, beat_cnt=0, last_data=0, err_cnt=0, seq_err=0, drain counter=0, and the checker to "unarmed". ready is 0 whenever rst_n==0, gated combinationally.
- ready = rst_n && (level != DEPTH). It depends only on registered state, never on valid.
- Push: valid && ready at an edge writes data at the write pointer, and the pointer advances mod DEPTH. beat_cnt increments, wrapping at 2^32.
- Drain counter: free-running 0..DRAIN_PERIOD-1. A tick occurs when the counter == DRAIN_PERIOD-1. With DRAIN_PERIOD=1, every cycle is a tick.
- Pop: tick && level != 0. The word at the read pointer is drained, the pointer advances mod DEPTH, and last_data is set to that word. A tick with an empty FIFO is lost and is not carried forward.
- Simultaneous push and pop: level is unchanged and both pointers advance. When full, ready=0, so no push coincides with a pop from full. A pop from full raises ready the next cycle.
- Level update: +1 on push only, −1 on pop only, otherwise unchanged.
- Checker, on each pop:
  - If unarmed: arm, and set expect = word+1. There is no error on the first word.
  - If armed and word != expect: err_cnt increments, saturating at 2^ERR_W−1, and seq_err=1 for the next cycle. Then expect = word+1, so the checker resyncs to the observed value.
  - If armed and word == expect: expect = word+1.
  - All expect arithmetic is mod 2^DATA_W, so 0xFFFFFFFF followed by 0 is valid.
- The data value is ignored when valid=0. Data is not required to be stable while valid && !ready; each word is sampled only at its handshake edge.

## Timing
- Push at edge t updates level and beat_cnt visible after t. ready reflects the new level in the same cycle after t, with no extra registration.
- A word pushed at edge t into an empty FIFO can be drained at the first tick edge ≥ t+1. Minimum push-to-last_data latency is 1 cycle.
- seq_err is asserted for exactly the cycle following the mismatching pop edge. err_cnt updates at the pop edge.
- FIFO order is strict first-in, first-out. No word is dropped or duplicated.
- Reset mid-operation:
  - FIFO contents are discarded and counters are zeroed.
  - The checker is unarmed, and the first post-reset word is not an error.
  - ready is 0 during reset cycles and 1 the cycle after rst_n rises.
- With continuous valid and DRAIN_PERIOD=P: after the FIFO fills, sustained throughput is 1 accepted beat per P cycles.

## Test plan
- Reset, then idle with valid=0 for 10 cycles -> ready=1, level=0, beat_cnt=0, last_data=0, err_cnt=0.
- Master sends 1,2,3,… continuously with DEPTH=4, DRAIN_PERIOD=3 -> level reaches 4 and ready drops. Thereafter ready=1 one cycle in three, last_data steps 1,2,3,… and err_cnt stays 0.
- Same stream with DRAIN_PERIOD=1 -> ready stays 1, level ≤1, beat_cnt equals the cycle count of valid, and last_data lags data by 1 cycle.
- Inject the sequence 5,6,9,10 -> one seq_err pulse after 9 drains, err_cnt=1. No error on 10 because the checker resynced.
- Sequence 0xFFFFFFFE, 0xFFFFFFFF, 0, 1 -> err_cnt=0, and last_data ends at 1.
- Assert rst_n=0 for 2 cycles while level=3 -> ready=0 during reset and level=0 after. The next word (e.g. 100) is accepted without error, then 101 is accepted without error.

Source files
------------

// File: rtl/axis_slave_rx_if.sv
// Valid/ready streaming handshake bundle: the master drives data/valid, the slave drives ready.
interface axis_slave_rx_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] data;
    logic              valid;
    logic              ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/axis_slave_rx.sv
// Streaming sink: buffers handshaked words in a small FIFO, drains one word every DRAIN_PERIOD
// cycles and checks that the drained words form an incrementing sequence.
module axis_slave_rx #(
    parameter int DATA_W       = 32,
    parameter int DEPTH        = 4,
    parameter int DRAIN_PERIOD = 3,
    parameter int ERR_W        = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    axis_slave_rx_if.slave          s_axis,
    output logic [$clog2(DEPTH):0]  level,
    output logic [31:0]             beat_cnt,
    output logic [DATA_W-1:0]       last_data,
    output logic [ERR_W-1:0]        err_cnt,
    output logic                    seq_err
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LVL_W = $clog2(DEPTH) + 1;
    localparam int CNT_W = (DRAIN_PERIOD > 1) ? $clog2(DRAIN_PERIOD) : 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);
    localparam logic [CNT_W-1:0] TICK_CNT = CNT_W'(DRAIN_PERIOD - 1);
    localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic [CNT_W-1:0]  drain_cnt_q, drain_cnt_d;
    logic [31:0]       beat_cnt_q, beat_cnt_d;
    logic [DATA_W-1:0] last_data_q, last_data_d;
    logic [DATA_W-1:0] expect_q, expect_d;
    logic              armed_q, armed_d;
    logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
    logic              seq_err_q, seq_err_d;

    logic              ready_s;
    logic              push_s;
    logic              tick_s;
    logic              pop_s;
    logic [DATA_W-1:0] pop_word_s;

    // Handshake qualifiers; ready looks only at registered occupancy, never at valid.
    always_comb begin
        ready_s    = rst_n && (level_q != FULL_LVL);
        push_s     = s_axis.valid && ready_s;
        tick_s     = (drain_cnt_q == TICK_CNT);
        pop_s      = tick_s && (level_q != {LVL_W{1'b0}});
        pop_word_s = mem_q[rd_ptr_q];
    end

    assign s_axis.ready = ready_s;

    // FIFO storage, pointers, occupancy and the free-running drain counter.
    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        beat_cnt_d = beat_cnt_q;
        level_d    = level_q;

        if (push_s) begin
            mem_d[wr_ptr_q] = s_axis.data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            beat_cnt_d      = beat_cnt_q + 32'd1;
        end else begin
            wr_ptr_d   = wr_ptr_q;
            beat_cnt_d = beat_cnt_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase

        // A tick that finds the FIFO empty is simply lost.
        if (tick_s) begin
            drain_cnt_d = {CNT_W{1'b0}};
        end else begin
            drain_cnt_d = drain_cnt_q + CNT_W'(1);
        end
    end

    // Sequence checker: the first drained word only arms it; afterwards it resyncs to each word.
    always_comb begin
        last_data_d = last_data_q;
        armed_d     = armed_q;
        expect_d    = expect_q;
        err_cnt_d   = err_cnt_q;
        seq_err_d   = 1'b0;

        if (pop_s) begin
            last_data_d = pop_word_s;
            armed_d     = 1'b1;
            expect_d    = pop_word_s + DATA_W'(1);
            if (armed_q && (pop_word_s != expect_q)) begin
                seq_err_d = 1'b1;
                if (err_cnt_q != ERR_MAX) begin
                    err_cnt_d = err_cnt_q + ERR_W'(1);
                end else begin
                    err_cnt_d = err_cnt_q;
                end
            end else begin
                seq_err_d = 1'b0;
            end
        end else begin
            last_data_d = last_data_q;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {DATA_W{1'b0}};
            end
            wr_ptr_q    <= {PTR_W{1'b0}};
            rd_ptr_q    <= {PTR_W{1'b0}};
            level_q     <= {LVL_W{1'b0}};
            drain_cnt_q <= {CNT_W{1'b0}};
            beat_cnt_q  <= 32'd0;
            last_data_q <= {DATA_W{1'b0}};
            expect_q    <= {DATA_W{1'b0}};
            armed_q     <= 1'b0;
            err_cnt_q   <= {ERR_W{1'b0}};
            seq_err_q   <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            drain_cnt_q <= drain_cnt_d;
            beat_cnt_q  <= beat_cnt_d;
            last_data_q <= last_data_d;
            expect_q    <= expect_d;
            armed_q     <= armed_d;
            err_cnt_q   <= err_cnt_d;
            seq_err_q   <= seq_err_d;
        end
    end

    assign level     = level_q;
    assign beat_cnt  = beat_cnt_q;
    assign last_data = last_data_q;
    assign err_cnt   = err_cnt_q;
    assign seq_err   = seq_err_q;
endmodule

// File: tb/tb_axis_slave_rx.sv
// Directed bench: one sink drains every 3rd cycle, a second one every cycle; both share clk/rst_n.
module tb_axis_slave_rx;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    axis_slave_rx_if #(.DATA_W(32)) if3 ();
    axis_slave_rx_if #(.DATA_W(32)) if1 ();

    logic [2:0]  level3, level1;
    logic [31:0] beat3, beat1, last3, last1;
    logic [15:0] err3, err1;
    logic        serr3, serr1;

    axis_slave_rx #(.DATA_W(32), .DEPTH(4), .DRAIN_PERIOD(3), .ERR_W(16)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .s_axis(if3), .level(level3), .beat_cnt(beat3),
        .last_data(last3), .err_cnt(err3), .seq_err(serr3));

    axis_slave_rx #(.DATA_W(32), .DEPTH(4), .DRAIN_PERIOD(1), .ERR_W(16)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .s_axis(if1), .level(level1), .beat_cnt(beat1),
        .last_data(last1), .err_cnt(err1), .seq_err(serr1));

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] q3[$];
    logic [31:0] q1[$];
    int lvl_tab[5] = '{1, 2, 2, 3, 4};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        if3.valid = (q3.size() != 0);
        if3.data  = (q3.size() != 0) ? q3[0] : 32'hDEAD_BEEF;
        if1.valid = (q1.size() != 0);
        if1.data  = (q1.size() != 0) ? q1[0] : 32'hDEAD_BEEF;
    endtask

    task automatic step();
        logic hs3, hs1;
        hs3 = if3.valid && if3.ready;
        hs1 = if1.valid && if1.ready;
        @(posedge clk);
        #1;
        if (hs3) void'(q3.pop_front());
        if (hs1) void'(q1.pop_front());
        drive();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        q3.delete();
        q1.delete();
        drive();
        #1;
        check("rst_ready3", 64'(if3.ready), 64'd0);
        check("rst_ready1", 64'(if1.ready), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_level3", 64'(level3), 64'd0);
        check("rst_ready3_hold", 64'(if3.ready), 64'd0);
        rst_n = 1'b1;
        #1;
        check("post_rst_ready3", 64'(if3.ready), 64'd1);
        check("post_rst_ready1", 64'(if1.ready), 64'd1);
        check("post_rst_beat3", 64'(beat3), 64'd0);
        check("post_rst_last3", 64'(last3), 64'd0);
        check("post_rst_err3", 64'(err3), 64'd0);
        check("post_rst_serr3", 64'(serr3), 64'd0);
    endtask

    initial begin
        // Reset then idle for 10 cycles.
        do_reset();
        repeat (10) step();
        check("idle_ready3", 64'(if3.ready), 64'd1);
        check("idle_level3", 64'(level3), 64'd0);
        check("idle_beat3", 64'(beat3), 64'd0);
        check("idle_last3", 64'(last3), 64'd0);
        check("idle_err3", 64'(err3), 64'd0);
        check("idle_ready1", 64'(if1.ready), 64'd1);
        check("idle_level1", 64'(level1), 64'd0);

        // Continuous 1,2,3,... into both sinks.
        do_reset();
        for (int i = 1; i <= 40; i++) begin
            q3.push_back(32'(i));
            q1.push_back(32'(i));
        end
        drive();
        for (int n = 1; n <= 30; n++) begin
            step();
            check("p3_ready", 64'(if3.ready), ((n < 5) || (n % 3 == 0)) ? 64'd1 : 64'd0);
            check("p3_level", 64'(level3), (n <= 5) ? 64'(lvl_tab[n-1]) : ((n % 3 == 0) ? 64'd3 : 64'd4));
            check("p3_last", 64'(last3), 64'(n / 3));
            check("p3_beat", 64'(beat3), (n <= 5) ? 64'(n) : 64'(4 + (n - 1) / 3));
            check("p1_ready", 64'(if1.ready), 64'd1);
            check("p1_level", 64'(level1), 64'd1);
            check("p1_beat", 64'(beat1), 64'(n));
            check("p1_last", 64'(last1), 64'(n - 1));
        end
        check("p3_err", 64'(err3), 64'd0);
        check("p1_err", 64'(err1), 64'd0);

        // 5,6,9,10: exactly one error, on 9; 10 is accepted after resync.
        do_reset();
        q3 = '{32'd5, 32'd6, 32'd9, 32'd10};
        drive();
        for (int n = 1; n <= 15; n++) begin
            step();
            check("gap_serr", 64'(serr3), (n == 9) ? 64'd1 : 64'd0);
            if (n == 8) begin
                check("gap_err_pre", 64'(err3), 64'd0);
                check("gap_last_pre", 64'(last3), 64'd6);
            end else if (n == 9) begin
                check("gap_err", 64'(err3), 64'd1);
                check("gap_last", 64'(last3), 64'd9);
            end else if (n == 12) begin
                check("gap_last_end", 64'(last3), 64'd10);
                check("gap_level_end", 64'(level3), 64'd0);
            end
        end
        check("gap_err_end", 64'(err3), 64'd1);

        // Wrap through 0xFFFFFFFF -> 0 is a valid increment.
        do_reset();
        q3 = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
        drive();
        for (int n = 1; n <= 12; n++) begin
            step();
            check("wrap_serr", 64'(serr3), 64'd0);
            if (n == 9) check("wrap_last_zero", 64'(last3), 64'd0);
        end
        check("wrap_last", 64'(last3), 64'd1);
        check("wrap_err", 64'(err3), 64'd0);
        check("wrap_level", 64'(level3), 64'd0);

        // Reset with level 3; the checker must come back unarmed.
        do_reset();
        q3 = '{32'd20, 32'd21, 32'd22, 32'd23};
        drive();
        repeat (4) step();
        check("mid_level_pre", 64'(level3), 64'd3);
        check("mid_beat_pre", 64'(beat3), 64'd4);
        do_reset();
        check("mid_level_post", 64'(level3), 64'd0);
        q3 = '{32'd100, 32'd101};
        drive();
        for (int n = 1; n <= 7; n++) begin
            step();
            check("mid_serr", 64'(serr3), 64'd0);
            if (n == 3) begin
                check("mid_last100", 64'(last3), 64'd100);
                check("mid_level1", 64'(level3), 64'd1);
            end else if (n == 6) begin
                check("mid_last101", 64'(last3), 64'd101);
                check("mid_level0", 64'(level3), 64'd0);
            end
        end
        check("mid_err", 64'(err3), 64'd0);
        check("mid_beat", 64'(beat3), 64'd2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
